// File: rtl/mux_sched_pkg.sv
// Shared widths, FSM state encoding and helpers for the 64-channel mux scheduler.
package mux_sched_pkg;

    localparam int unsigned N_CH  = 64;
    localparam int unsigned SEL_W = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OFFER  = 2'd2
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0] id;
        logic             data;
    } grant_t;

    function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick64.sv
// Rotating-priority finder: lowest set request bit at or above ptr, wrapping to 0.
module rr_pick64
    import mux_sched_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] id
);

    logic [N_CH-1:0]   mask;
    logic [2*N_CH-1:0] dbl;

    // Lower half keeps only bits >= ptr; upper half is the wrapped copy of all bits.
    always_comb begin
        mask = ~((N_CH'(1) << ptr) - N_CH'(1));
        dbl  = {req, req & mask};
        any  = |req;
        id   = '0;
        for (int i = int'(2 * N_CH) - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                id = i[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mux64_rr_scheduler.sv
// Round-robin owner of the 64:1 mux select: grant, settle, sample, offer, ack.
module mux64_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    output logic [SEL_W-1:0] mux_sel,
    input  logic             mux_out,
    output logic             grant_valid,
    input  logic             grant_ready,
    output logic [SEL_W-1:0] grant_id,
    output logic             grant_data,
    output logic [N_CH-1:0]  ack
);

    localparam int unsigned CNT_W = 4;

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic             pick_any;
    logic [SEL_W-1:0] pick_id;

    rr_pick64 u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .id  (pick_id)
    );

    // Scheduler FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            mux_sel     <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            grant_data  <= 1'b0;
            ack         <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        mux_sel  <= pick_id;
                        grant_id <= pick_id;
                        cnt      <= CNT_W'(SETTLE_CYCLES - 1);
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        grant_data  <= mux_out;
                        grant_valid <= 1'b1;
                        state       <= OFFER;
                    end
                end
                OFFER: begin
                    if (grant_ready) begin
                        grant_valid <= 1'b0;
                        ack         <= onehot(grant_id);
                        ptr         <= grant_id + SEL_W'(1);
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux64_rr_scheduler.sv
// Scoreboard bench for mux64_rr_scheduler: default build plus a SETTLE_CYCLES=4 build.
module tb_mux64_rr_scheduler;
    import mux_sched_pkg::*;

    localparam logic [63:0] PAT = 64'hA5A5_3C3C_0F0F_9669;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, grant_ready, mux_out, grant_valid, grant_data;
    logic [63:0] req, ack, in_vec;
    logic [5:0]  mux_sel, grant_id;

    logic        rst4, ready4, out4, valid4, data4;
    logic [63:0] req4, ack4, in4;
    logic [5:0]  sel4, id4;

    assign mux_out = in_vec[mux_sel];
    assign out4    = in4[sel4];

    mux64_rr_scheduler dut (
        .clk(clk), .rst(rst), .req(req), .mux_sel(mux_sel), .mux_out(mux_out),
        .grant_valid(grant_valid), .grant_ready(grant_ready), .grant_id(grant_id),
        .grant_data(grant_data), .ack(ack)
    );

    mux64_rr_scheduler #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst4), .req(req4), .mux_sel(sel4), .mux_out(out4),
        .grant_valid(valid4), .grant_ready(ready4), .grant_id(id4),
        .grant_data(data4), .ack(ack4)
    );

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          hs_count = 0;
    int          rr_last  = 0;
    bit          rr_phase = 1'b0;
    bit          rr_seen  = 1'b0;
    logic [63:0] exp_ack  = '0;
    grant_t      sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id);
        grant_t g;
        g.id   = SEL_W'(id);
        g.data = in_vec[g.id];
        sb.push_back(g);
    endtask

    task automatic wait_hs(input int n);
        int target;
        target = hs_count + n;
        for (int k = 0; k < 2000; k++) begin
            if (hs_count >= target) return;
            tick();
        end
        check("hs_timeout", 64'(hs_count), 64'(target));
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 100; k++) begin
            if (grant_valid === 1'b1) return;
            tick();
        end
        check("valid_timeout", {63'd0, grant_valid}, 64'd1);
    endtask

    // Monitor: ack model every cycle, scoreboard pop on each handshake.
    always @(negedge clk) begin
        grant_t e;
        cyc++;
        check("ack", ack, exp_ack);
        exp_ack = '0;
        if (!rr_phase) rr_seen = 1'b0;
        if (!rst && grant_valid === 1'b1 && grant_ready) begin
            hs_count++;
            if (sb.size() == 0) begin
                check("unexpected_grant", {58'd0, grant_id}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("grant_id", {58'd0, grant_id}, {58'd0, e.id});
                check("grant_data", {63'd0, grant_data}, {63'd0, e.data});
                exp_ack = onehot(e.id);
            end
            if (rr_phase) begin
                if (rr_seen) check("rr_spacing", 64'(cyc - rr_last), 64'd3);
                rr_seen = 1'b1;
                rr_last = cyc;
            end
        end
    end

    initial begin
        rst = 1'b1; req = '0; grant_ready = 1'b0; in_vec = '0;
        rst4 = 1'b1; req4 = '0; ready4 = 1'b0; in4 = '0;
        tick(); tick();
        check("rst_valid", {63'd0, grant_valid}, 64'd0);
        check("rst_id", {58'd0, grant_id}, 64'd0);
        check("rst_data", {63'd0, grant_data}, 64'd0);
        check("rst_sel", {58'd0, mux_sel}, 64'd0);

        // Single request and two-cycle latency
        rst = 1'b0; in_vec = 64'h1; grant_ready = 1'b1; req = 64'h1;
        push(0);
        tick();
        check("lat_settle", {63'd0, grant_valid}, 64'd0);
        req = '0;
        tick();
        check("lat_valid", {63'd0, grant_valid}, 64'd1);
        wait_hs(1);

        // ptr=1 after serving 0: channel 1 wins, then wrap to 0
        req = 64'h3;
        push(1); push(0);
        wait_hs(2);
        req = '0;

        // Full round robin from ptr 0
        rst = 1'b1; tick(); rst = 1'b0;
        in_vec = PAT;
        for (int i = 0; i < 64; i++) push(i);
        push(0);
        rr_phase = 1'b1;
        req = '1;
        wait_hs(65);
        req = '0;
        rr_phase = 1'b0;

        // Serve 40, then {5,40}: wrap gives 5 before 40
        req = 64'h1 << 40;
        push(40);
        wait_hs(1);
        req = (64'h1 << 5) | (64'h1 << 40);
        push(5); push(40);
        wait_hs(2);
        req = '0;

        // Backpressure with toggling req and mux inputs
        grant_ready = 1'b0;
        req = 64'h1 << 12;
        push(12);
        wait_valid();
        for (int k = 0; k < 10; k++) begin
            req = ~req;
            in_vec = ~in_vec;
            tick();
            check("bp_valid", {63'd0, grant_valid}, 64'd1);
            check("bp_id", {58'd0, grant_id}, 64'd12);
            check("bp_data", {63'd0, grant_data}, {63'd0, PAT[12]});
            check("bp_sel", {58'd0, mux_sel}, 64'd12);
        end
        req = '0;
        grant_ready = 1'b1;
        wait_hs(1);
        tick(); tick();

        // Request withdrawn during SETTLE still completes
        req = 64'h1 << 7;
        push(7);
        tick();
        req = '0;
        wait_hs(1);

        // Reset during OFFER abandons the grant and clears ptr
        grant_ready = 1'b0;
        req = 64'h1 << 20;
        wait_valid();
        req = '0;
        rst = 1'b1; grant_ready = 1'b1;
        tick();
        check("rstoff_valid", {63'd0, grant_valid}, 64'd0);
        check("rstoff_sel", {58'd0, mux_sel}, 64'd0);
        check("rstoff_ack", ack, 64'd0);
        rst = 1'b0;
        req = (64'h1 << 3) | (64'h1 << 50);
        push(3); push(50);
        wait_hs(2);
        req = '0;

        // SETTLE_CYCLES=4: valid after 5 edges, late sample of mux_out
        rst4 = 1'b0; ready4 = 1'b0; in4 = '0;
        req4 = 64'h1 << 63;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("s4_not_valid", {63'd0, valid4}, 64'd0);
            if (k == 3) in4 = 64'h1 << 63;
        end
        tick();
        check("s4_valid", {63'd0, valid4}, 64'd1);
        check("s4_id", {58'd0, id4}, 64'd63);
        check("s4_data", {63'd0, data4}, 64'd1);
        check("s4_sel", {58'd0, sel4}, 64'd63);
        req4 = '0; in4 = '0;
        tick();
        check("s4_hold_data", {63'd0, data4}, 64'd1);
        check("s4_hold_ack", ack4, 64'd0);
        ready4 = 1'b1;
        tick();
        check("s4_hs_valid", {63'd0, valid4}, 64'd0);
        check("s4_ack", ack4, 64'h1 << 63);
        tick();
        check("s4_ack_clear", ack4, 64'd0);

        tick(); tick();
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
